// File: rtl/valid_ready_pkg.sv
// Shared helpers for the valid/ready stream FIFO: pointer width and
// elaboration-time checks on the DEPTH parameter.
package valid_ready_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth_is_pow2(depth) && (depth >= 2);
  endfunction

endpackage

// File: rtl/valid_ready_std_if.sv
// Standard valid/ready stream interface; the producer drives valid/data
// and the consumer drives ready.
interface valid_ready_std_if #(
  parameter int DATAWIDTH = 8
) ();
  logic                 valid;
  logic                 ready;
  logic [DATAWIDTH-1:0] data;

  modport in  (input valid, input data, output ready);
  modport out (output valid, output data, input ready);
endinterface

// File: rtl/valid_ready_fifo_mem.sv
// DEPTH x DATAWIDTH storage for the stream FIFO: synchronous write,
// asynchronous read, no reset.
module valid_ready_fifo_mem #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATAWIDTH-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATAWIDTH-1:0]       rdata
);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/valid_ready_fifo.sv
// Elastic valid/ready buffer with registered ready/valid (no in->out comb path).
// Optional occupancy port enabled by VALID_READY_FIFO_COUNT_EN.
module valid_ready_fifo
  import valid_ready_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  valid_ready_std_if.in               in_if,
  valid_ready_std_if.out              out_if
`ifdef VALID_READY_FIFO_COUNT_EN
  ,
  output logic [ptr_w(DEPTH)-1:0]     count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("valid_ready_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_next, rd_next;
  logic          ready_q, valid_q;
  logic          push, pop;
  logic          full_next, empty_next;

  assign push = in_if.valid && ready_q;
  assign pop  = valid_q && out_if.ready;

  assign wr_next = wr_ptr + PW'(push);
  assign rd_next = rd_ptr + PW'(pop);

  // Flags are evaluated on the post-update pointers so ready/valid can be registered.
  assign empty_next = (wr_next == rd_next);
  assign full_next  = (wr_next[AW-1:0] == rd_next[AW-1:0]) &&
                      (wr_next[AW] != rd_next[AW]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      ready_q <= !full_next;
      valid_q <= !empty_next;
    end
  end

  assign in_if.ready  = ready_q;
  assign out_if.valid = valid_q;

  valid_ready_fifo_mem #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_if.data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_if.data)
  );

`ifdef VALID_READY_FIFO_COUNT_EN
  logic [PW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= wr_next - rd_next;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Self-checking bench for valid_ready_fifo: fixed vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_valid_ready_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  valid_ready_std_if #(.DATAWIDTH(DW)) in_if ();
  valid_ready_std_if #(.DATAWIDTH(DW)) out_if ();

`ifdef VALID_READY_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  valid_ready_fifo #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if),
    .out_if (out_if)
`ifdef VALID_READY_FIFO_COUNT_EN
    ,
    .count  (count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, handshake flags from occupancy.
  logic [DW-1:0] q[$];
  bit            m_ready;
  bit            m_valid;

  typedef struct {
    bit          iv;
    logic [7:0]  id;
    bit          ordy;
    bit          e_ready;
    bit          e_valid;
    bit          chk_d;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, "_ready"}, 32'(in_if.ready), 32'(m_ready));
    check({tag, "_valid"}, 32'(out_if.valid), 32'(m_valid));
    if (m_valid) check({tag, "_data"}, 32'(out_if.data), 32'(q[0]));
`ifdef VALID_READY_FIFO_COUNT_EN
    check({tag, "_count"}, 32'(count), 32'(q.size()));
`endif
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at posedge+1.
  task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input string tag);
    bit push;
    bit pop;
    @(negedge clk);
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    @(posedge clk);
    if (!rst) begin
      push = iv && m_ready;
      pop  = m_valid && ordy;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(id);
      m_ready = (q.size() < DEPTH);
      m_valid = (q.size() > 0);
    end
    #1;
    model_check(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, tag);
  endtask

  logic [7:0] cur_d;
  bit         cur_v;
  bit         acc;

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset release
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_ready", 32'(in_if.ready), 32'd0);
      check("rst_valid", 32'(out_if.valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ready_pre", 32'(in_if.ready), 32'd0);
    step(1'b0, 8'h00, 1'b0, "release");
    check("release_ready", 32'(in_if.ready), 32'd1);
    check("release_valid", 32'(out_if.valid), 32'd0);

    // Fill and drain table
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].ordy, "tbl_model");
      check($sformatf("tbl%0d_ready", i), 32'(in_if.ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_valid", i), 32'(out_if.valid), 32'(tbl[i].e_valid));
      if (tbl[i].chk_d)
        check($sformatf("tbl%0d_data", i), 32'(out_if.data), 32'(tbl[i].e_data));
    end

    // Streaming: 16 words, one per cycle, pointers wrap four times
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, "stream");
      check("stream_data", 32'(out_if.data), 32'(8'h80 + i));
    end
    drain("stream_drain");
    check("stream_empty", 32'(out_if.valid), 32'd0);

    // Full with simultaneous traffic
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, "full_fill");
    check("full_ready", 32'(in_if.ready), 32'd0);
    step(1'b1, 8'hB0, 1'b1, "full_both");
    check("full_both_ready", 32'(in_if.ready), 32'd1);
    check("full_both_data", 32'(out_if.data), 32'hA1);
`ifdef VALID_READY_FIFO_COUNT_EN
    check("full_both_count", 32'(count), 32'd3);
`endif
    step(1'b1, 8'hB0, 1'b0, "full_refill");
    check("full_refill_ready", 32'(in_if.ready), 32'd0);
`ifdef VALID_READY_FIFO_COUNT_EN
    check("full_refill_count", 32'(count), 32'd4);
`endif
    drain("full_drain");

    // Random backpressure with a well-behaved producer
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 200; i++) begin
      if (!cur_v || acc) begin
        cur_v = 1'($urandom_range(0, 1));
        cur_d = 8'($urandom);
      end
      acc = cur_v && m_ready;
      step(cur_v, cur_d, 1'($urandom_range(0, 1)), "rand");
    end
    drain("rand_drain");

    // Async reset mid-burst with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, "ar_fill");
    check("ar_stored_valid", 32'(out_if.valid), 32'd1);
    @(negedge clk);
    in_if.valid = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("ar_ready_drop", 32'(in_if.ready), 32'd0);
    check("ar_valid_drop", 32'(out_if.valid), 32'd0);
`ifdef VALID_READY_FIFO_COUNT_EN
    check("ar_count_drop", 32'(count), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, "ar_release");
    check("ar_post_valid", 32'(out_if.valid), 32'd0);
    check("ar_post_ready", 32'(in_if.ready), 32'd1);
    step(1'b1, 8'hD5, 1'b0, "ar_push");
    check("ar_push_data", 32'(out_if.data), 32'hD5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/valid_ready_fifo.md
# valid_ready_fifo

Synchronous stream FIFO that terminates a valid/ready producer on its `in` side and acts as producer on its `out` side. It is the standard elastic buffer between `valid_ready_std_if` endpoints. It decouples producer and consumer stall patterns and absorbs bursts of up to DEPTH words. There is no combinational path between its input and output handshakes.

## Interface
- DATAWIDTH, 8, payload width; must equal the DATAWIDTH of both connected interface instances.
- DEPTH, 4, number of storage entries; power of two, minimum 2.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_if  valid_ready_std_if.in  DATAWIDTH+2  upstream side: samples valid/data, drives ready.
- out_if  valid_ready_std_if.out  DATAWIDTH+2  downstream side: drives valid/data, samples ready.
- count  output  $clog2(DEPTH)+1  occupancy; present only with VALID_READY_FIFO_COUNT_EN.

## Operation
- Push: a push happens on a rising edge when in_if.valid && in_if.ready. in_if.data is written at wr_ptr, and wr_ptr increments.
- Pop: a pop happens on a rising edge when out_if.valid && out_if.ready, and rd_ptr increments.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. The low bits address storage and wrap DEPTH-1 -> 0.
- Empty and full:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
- in_if.ready is a register. Its next value is !full_next, where full_next is computed after this cycle's push/pop.
- out_if.valid is a register. Its next value is !empty_next.
- out_if.data = mem[rd_ptr low bits], read combinationally from the registered rd_ptr. It is stable while out_if.valid && !out_if.ready.
- out_if.valid, once asserted, stays asserted until a pop. The block never retracts valid.
- Simultaneous push and pop:
  - Both take effect and occupancy is unchanged.
  - When occupancy is DEPTH, no push can occur because ready is low. A pop that cycle raises ready for the next cycle.
  - When empty, no pop can occur. A push that cycle raises valid for the next cycle. There is no same-cycle bypass.
- Ordering: strict FIFO. No data is dropped or duplicated.
- Upstream obligations are the producer's responsibility and are not checked: valid/data stable until accepted.

## Timing
- Reset values while rst is high, asynchronously:
  - wr_ptr = rd_ptr = 0
  - in_if.ready = 0
  - out_if.valid = 0
  - count = 0
  - storage is not reset
- First clock edge after rst falls: in_if.ready becomes 1. The first push is possible on the following edge.
- Latency: a word pushed at edge N is visible with out_if.valid = 1 after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained, at any occupancy where neither side stalls.
- in_if.ready drops the cycle after the push that fills the FIFO. It rises the cycle after the pop that leaves DEPTH-1 entries.
- Reset asserted mid-transfer: all stored words are discarded immediately and both handshake outputs go low asynchronously.

## Configuration
- VALID_READY_FIFO_COUNT_EN defined:
  - The `count` port exists.
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1), registered with the pointers.
  - Range 0..DEPTH.
- Not defined: the `count` port and its logic are absent. Handshake behaviour is identical in both builds.

## Structure
- Package valid_ready_pkg:
  - ptr_w(depth) constant function, returning $clog2(depth)+1.
  - Elaboration-time check helpers: DEPTH is a power of two and ≥2.
- Sub-module valid_ready_fifo_mem:
  - DEPTH x DATAWIDTH register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - No reset.
- The top level holds pointers, flag registers, and the optional count.

## Test plan
- Reset release: rst held high for 3 cycles, then low -> ready = 0 and valid = 0 during reset; ready = 1 one edge after release; valid stays 0.
- Fill and drain, DEPTH = 4, out_if.ready = 0:
  - Push 0x11, 0x22, 0x33, 0x44 on 4 consecutive edges -> ready = 0 after the 4th edge; a 5th offered word 0x55 is not accepted.
  - Then raise out_if.ready -> out data is 0x11, 0x22, 0x33, 0x44 on consecutive cycles; valid drops after the 4th pop.
- Streaming: valid and ready held at 1 continuously, 16 incrementing words -> one word out per cycle after 1 cycle latency, in order, with pointers wrapping past entry 3 at least 3 times.
- Full with simultaneous traffic: FIFO full, in_if.valid = 1, out_if.ready = 1 for 1 cycle -> 1 pop, 0 pushes; next cycle ready = 1 and the push succeeds; count (if enabled) reads 4 -> 3 -> 4.
- Backpressure stability: out_if.ready toggled randomly for 200 cycles -> valid never falls without a pop; data constant while stalled; scoreboard matches input order.
- Async reset mid-burst: rst pulsed between clock edges with 3 words stored -> valid and ready drop immediately; after release valid stays 0 and count = 0.
